player_key_decoder: RTL and testbench

- Converts PS/2 set-2 scancode bytes into held-key levels for player_move_ctrl: left, right, jump.
- Also emits a one-cycle game-reset request.
- Sits between the PS/2 byte receiver and player_move_ctrl, in the 65 MHz pixel clock domain.
- Tracks make, break and E0-extended sequences so each output mirrors the physical key state.

---
 rtl/player_key_decoder_pkg.sv | 31 +++
 rtl/player_key_decoder_if.sv | 20 ++
 rtl/player_key_decoder.sv | 135 +++++++++++++
 tb/tb_player_key_decoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/player_key_decoder_pkg.sv
// Shared PS/2 set-2 scancode constants and decoder state type for player_key_decoder.
package player_key_decoder_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;

  localparam logic [7:0] DEF_KEY_LEFT  = 8'h6B;
  localparam logic [7:0] DEF_KEY_RIGHT = 8'h74;
  localparam logic [7:0] DEF_KEY_JUMP  = 8'h75;
  localparam logic [7:0] DEF_KEY_RESET = 8'h2D;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 65_000_000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } kbd_state_t;

  // Keyboard housekeeping bytes that carry no key information.
  function automatic logic is_ignored(input logic [7:0] code);
    return (code == SC_BAT) || (code == SC_ACK) ||
           (code == SC_ECHO) || (code == SC_RESEND);
  endfunction

endpackage

// File: rtl/player_key_decoder_if.sv
// Scancode byte input and held-key outputs of player_key_decoder.
interface player_key_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       left;
  logic       right;
  logic       jump;
  logic       reset_req;
  logic       err;

  modport master (
    output rx_data, rx_valid,
    input  left, right, jump, reset_req, err
  );

  modport slave (
    input  rx_data, rx_valid,
    output left, right, jump, reset_req, err
  );
endinterface

// File: rtl/player_key_decoder.sv
// PS/2 set-2 scancode decoder producing held left/right/jump levels and a reset pulse.
// Optional inactivity timeout enabled by defining PLAYER_KEY_TIMEOUT_EN.
module player_key_decoder
  import player_key_decoder_pkg::*;
#(
  parameter logic [7:0]  KEY_LEFT       = DEF_KEY_LEFT,
  parameter logic [7:0]  KEY_RIGHT      = DEF_KEY_RIGHT,
  parameter logic [7:0]  KEY_JUMP       = DEF_KEY_JUMP,
  parameter logic [7:0]  KEY_RESET      = DEF_KEY_RESET,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  player_key_decoder_if.slave bus
);

  kbd_state_t state, state_n;

  logic       apply, is_ext, is_brk, err_n;
  logic       timeout;
  logic       left_q, right_q, jump_q, reset_req_q, err_q, reset_held;
  logic [7:0] code;

  assign code = bus.rx_data;

`ifdef PLAYER_KEY_TIMEOUT_EN
  localparam logic [26:0] TIMEOUT_LIMIT = 27'(TIMEOUT_CYCLES);
  logic [26:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || bus.rx_valid) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TIMEOUT_LIMIT) begin
      idle_cnt <= idle_cnt + 27'd1;
    end
  end

  assign timeout = (idle_cnt == TIMEOUT_LIMIT) && !bus.rx_valid;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    apply   = 1'b0;
    is_ext  = 1'b0;
    is_brk  = 1'b0;
    err_n   = 1'b0;
    if (bus.rx_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (code == SC_EXT)      state_n = ST_EXT;
          else if (code == SC_BRK) state_n = ST_BRK;
          else if (!is_ignored(code)) apply = 1'b1;
        end
        ST_EXT: begin
          if (code == SC_BRK) begin
            state_n = ST_EXT_BRK;
          end else if (code == SC_EXT) begin
            err_n   = 1'b1;
            state_n = ST_EXT;
          end else begin
            apply   = 1'b1;
            is_ext  = 1'b1;
            state_n = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          // A stray prefix restarts the sequence at that prefix instead of completing a break.
          if (code == SC_EXT) begin
            err_n   = 1'b1;
            state_n = ST_EXT;
          end else if (code == SC_BRK) begin
            err_n   = 1'b1;
            state_n = ST_BRK;
          end else begin
            apply   = 1'b1;
            is_brk  = 1'b1;
            is_ext  = (state == ST_EXT_BRK);
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_n = ST_IDLE;
    end
  end

  logic hit_left, hit_right, hit_jump, hit_reset;

  assign hit_left  = apply &&  is_ext && (code == KEY_LEFT);
  assign hit_right = apply &&  is_ext && (code == KEY_RIGHT);
  assign hit_jump  = apply &&  is_ext && (code == KEY_JUMP);
  assign hit_reset = apply && !is_ext && (code == KEY_RESET);

  always_ff @(posedge clk) begin
    if (rst) begin
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      jump_q      <= 1'b0;
      reset_req_q <= 1'b0;
      err_q       <= 1'b0;
      reset_held  <= 1'b0;
    end else begin
      reset_req_q <= hit_reset && !is_brk && !reset_held;
      err_q       <= err_n;
      if (timeout) begin
        left_q     <= 1'b0;
        right_q    <= 1'b0;
        jump_q     <= 1'b0;
        reset_held <= 1'b0;
      end else begin
        if (hit_left)  left_q     <= !is_brk;
        if (hit_right) right_q    <= !is_brk;
        if (hit_jump)  jump_q     <= !is_brk;
        if (hit_reset) reset_held <= !is_brk;
      end
    end
  end

  assign bus.left      = left_q;
  assign bus.right     = right_q;
  assign bus.jump      = jump_q;
  assign bus.reset_req = reset_req_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_player_key_decoder.sv
// Scoreboard bench for player_key_decoder: stimulus queues expected {left,right,jump,reset_req,err}.
module tb_player_key_decoder;
  logic clk = 1'b0;
  logic rst;
  logic probe;

  always #5 clk = ~clk;

  player_key_decoder_if bus();

`ifdef PLAYER_KEY_TIMEOUT_EN
  player_key_decoder #(.TIMEOUT_CYCLES(100)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  player_key_decoder dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  logic [4:0] exp_q[$];
  string      name_q[$];
  int checks = 0;
  int errors = 0;

  task automatic send(input logic [7:0] b, input logic [4:0] exp, input string nm);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    probe        = 1'b0;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      probe        = 1'b0;
    end
  endtask

  task automatic check_now(input logic [4:0] exp, input string nm);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    probe        = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // Monitor: any cycle with a strobe or probe yields one registered response to compare.
  initial begin
    logic       present;
    logic [4:0] act, exp;
    string      nm;
    forever begin
      @(posedge clk);
      present = bus.rx_valid | probe;
      #1;
      if (present && !rst) begin
        act = {bus.left, bus.right, bus.jump, bus.reset_req, bus.err};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_response: got %b, no expectation queued", act);
        end else begin
          exp = exp_q.pop_front();
          nm  = name_q.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (left right jump reset_req err)", nm, act, exp);
          end
        end
      end
    end
  end

  initial begin
    rst          = 1'b1;
    probe        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_now(5'b00000, "reset_state");

    // Extended left make/break
    send(8'hE0, 5'b00000, "left_pre");
    send(8'h6B, 5'b10000, "left_make");
    idle(3);
    send(8'hE0, 5'b10000, "left_brk_e0");
    send(8'hF0, 5'b10000, "left_brk_f0");
    send(8'h6B, 5'b00000, "left_break");
    idle(2);

    // Keypad 4 and reset key
    send(8'h6B, 5'b00000, "keypad4");
    idle(1);
    send(8'h2D, 5'b00010, "reset_pulse");
    idle(1);
    send(8'h2D, 5'b00000, "reset_rpt1");
    send(8'h2D, 5'b00000, "reset_rpt2");
    send(8'h2D, 5'b00000, "reset_rpt3");
    idle(1);
    send(8'hF0, 5'b00000, "reset_brk_f0");
    send(8'h2D, 5'b00000, "reset_brk");
    send(8'h2D, 5'b00010, "reset_repulse");
    send(8'h2D, 5'b00000, "reset_b2b_rpt");
    send(8'hF0, 5'b00000, "reset_brk2_f0");
    send(8'h2D, 5'b00000, "reset_brk2");
    send(8'hE0, 5'b00000, "ext2d_pre");
    send(8'h2D, 5'b00000, "ext2d_no_reset");
    send(8'hAA, 5'b00000, "bat_ignored");
    send(8'h2D, 5'b00010, "reset_after_bat");
    send(8'hF0, 5'b00000, "reset_brk3_f0");
    send(8'h2D, 5'b00000, "reset_brk3");
    idle(2);

    // Right/jump independence, left+right together, typematic repeat
    send(8'hE0, 5'b00000, "r_pre");
    send(8'h74, 5'b01000, "right_make");
    send(8'hE0, 5'b01000, "j_pre");
    send(8'h75, 5'b01100, "jump_make");
    send(8'hE0, 5'b01100, "r_brk_e0");
    send(8'hF0, 5'b01100, "r_brk_f0");
    send(8'h74, 5'b00100, "right_break");
    send(8'hE0, 5'b00100, "l_pre");
    send(8'h6B, 5'b10100, "left_make2");
    send(8'hE0, 5'b10100, "r_pre2");
    send(8'h74, 5'b11100, "both_held");
    send(8'hE0, 5'b11100, "rpt_pre");
    send(8'h74, 5'b11100, "right_typematic");
    send(8'hE0, 5'b11100, "lb_e0");
    send(8'hF0, 5'b11100, "lb_f0");
    send(8'h6B, 5'b01100, "left_break2");
    send(8'hE0, 5'b01100, "rb_e0");
    send(8'hF0, 5'b01100, "rb_f0");
    send(8'h74, 5'b00100, "right_break2");
    send(8'hE0, 5'b00100, "jb_e0");
    send(8'hF0, 5'b00100, "jb_f0");
    send(8'h75, 5'b00000, "jump_break");
    idle(2);

    // Prefix errors
    send(8'hE0, 5'b00000, "ee_first");
    send(8'hE0, 5'b00001, "ee_err");
    send(8'h6B, 5'b10000, "ee_left");
    send(8'hF0, 5'b10000, "ff_first");
    send(8'hF0, 5'b10001, "ff_err");
    send(8'h75, 5'b10000, "ff_jump_unch");
    send(8'hE0, 5'b10000, "eff_e0");
    send(8'hF0, 5'b10000, "eff_f0");
    send(8'hF0, 5'b10001, "eff_err");
    send(8'h6B, 5'b10000, "eff_kp4_brk");
    send(8'hE0, 5'b10000, "lb3_e0");
    send(8'hF0, 5'b10000, "lb3_f0");
    send(8'h6B, 5'b00000, "left_break3");
    idle(2);

    // Reset mid-sequence discards the pending E0
    send(8'hE0, 5'b00000, "rst_pre");
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_now(5'b00000, "rst_mid_state");
    send(8'h6B, 5'b00000, "rst_discard");
    idle(1);

    // Back-to-back strobes, then E1 pause sequence
    send(8'hE0, 5'b00000, "b2b_e0");
    send(8'h74, 5'b01000, "b2b_right");
    send(8'hE1, 5'b01000, "pause_e1");
    send(8'h14, 5'b01000, "pause_14");
    send(8'h77, 5'b01000, "pause_77");
    send(8'hE1, 5'b01000, "pause_e1b");
    send(8'hF0, 5'b01000, "pause_f0");
    send(8'h14, 5'b01000, "pause_14b");
    send(8'hF0, 5'b01000, "pause_f0b");
    send(8'h77, 5'b01000, "pause_77b");
    send(8'hE0, 5'b01000, "b2b_rb_e0");
    send(8'hF0, 5'b01000, "b2b_rb_f0");
    send(8'h74, 5'b00000, "b2b_right_brk");
    idle(1);

    // Held jump with no further traffic
    send(8'hE0, 5'b00000, "hold_pre");
    send(8'h75, 5'b00100, "hold_jump");
`ifdef PLAYER_KEY_TIMEOUT_EN
    idle(50);
    check_now(5'b00100, "timeout_alive");
    idle(100);
    check_now(5'b00000, "timeout_drop");
    send(8'hE0, 5'b00000, "post_to_e0");
    send(8'hF0, 5'b00000, "post_to_f0");
    send(8'h75, 5'b00000, "post_to_brk");
`else
    idle(1000);
    check_now(5'b00100, "hold_no_timeout");
    send(8'hE0, 5'b00100, "hold_rel_e0");
    send(8'hF0, 5'b00100, "hold_rel_f0");
    send(8'h75, 5'b00000, "hold_release");
`endif
    idle(4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
